// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the hazard sequencer.
//   hz_state_e : sequencer states (RUN, HOLD, FLUSH)
//   NOP_INSTR  : encoding loaded into IF/ID on a flush (addi x0,x0,0)
//   REG_AW_DEF : default register-address width
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } hz_state_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
    localparam int          REG_AW_DEF = 5;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clk   : clock
//   reset : synchronous clear to zero
//   inc   : count this cycle
//   q     : current count; sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//   in : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2 (ID sources), ex_rd/ex_mem_read (EX load),
//        ex_branch_taken (EX redirect), mem_busy (data memory stall)
//   out: pc_we, ifid_we, ifid_flush, idex_bubble, pipe_hold (stage register controls),
//        stall_cnt / flush_cnt (saturating perf counters)
// Controls are combinational from state_q and the inputs so a hazard is acted on the cycle
// it appears; only the state, the flush countdown and the counters are registered.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_busy,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pipe_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int FCNT_W = 4;
    localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);

    hz_state_e         state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              load_use;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // HOLD behaves exactly like RUN: while mem_busy it freezes, and on the first free
    // cycle the RUN decisions apply to the current inputs. Only FLUSH differs.
    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        state_d     = ST_RUN;
        fcnt_d      = fcnt_q;

        if (reset) begin
            pc_we       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            fcnt_d      = '0;
        end else if (mem_busy) begin
            // Freeze everything; a pending flush keeps its countdown.
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            pipe_hold = 1'b1;
            state_d   = (state_q == ST_FLUSH) ? ST_FLUSH : ST_HOLD;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                fcnt_d  = FCNT_LOAD;
                state_d = ST_FLUSH;
            end
        end else if (state_q == ST_FLUSH) begin
            // Wrong-path instructions are being killed; a load-use on them is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            if (fcnt_q <= FCNT_W'(1)) begin
                fcnt_d = '0;
            end else begin
                fcnt_d  = fcnt_q - FCNT_W'(1);
                state_d = ST_FLUSH;
            end
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~pc_we),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (ifid_flush),
        .q     (flush_cnt)
    );

endmodule
